inst_fetch_buf: RTL and testbench

Instruction fetch stage with a prefetch FIFO, sitting directly upstream of the IF/ID pipeline register. It owns the fetch PC and issues one-outstanding requests to a variable-latency instruction memory. It buffers returned instructions with their PC and presents them to IF/ID. It honours the load-use stall and the M-stage branch/jump redirect, which flushes the buffer and squashes in-flight responses.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_fifo.sv | 56 +++++
 rtl/inst_fetch_buf.sv | 119 +++++++++++
 tb/tb_inst_fetch_buf.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage: FSM states, NOP encoding and
// the buffered fetch entry.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {pc, inst} entries; clear wins over push and pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  // Guard against popping empty or pushing into a full FIFO without a pop.
  always_comb begin
    do_pop  = pop && (count != '0);
    do_push = push && ((count < CW'(DEPTH)) || do_pop);
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage; contents are only meaningful below count, so no reset.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/inst_fetch_buf.sv
// Fetch stage: owns the fetch PC, keeps one request outstanding to a
// variable-latency memory and buffers responses ahead of IF/ID.
module inst_fetch_buf
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] RedirTarg,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemAck,
  input  logic [31:0] ImemData,
  output logic        I_Valid,
  output logic [31:0] I_PC,
  output logic [31:0] I_PC4,
  output logic [31:0] I_Inst
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e  state;
  logic [31:0]   fetch_pc;
  logic [31:0]   target;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          push;
  logic          pop;
  logic          credit;
  fetch_entry_t  push_entry;
  fetch_entry_t  head;

  // Credit uses next-cycle occupancy, so a push or pop this cycle is accounted.
  always_comb begin
    target     = align_word(RedirTarg);
    push       = ImemAck && (state == WAIT) && !Redirect;
    pop        = I_Valid && !Stall && !Redirect;
    count_next = count + CW'(push) - CW'(pop);
    credit     = count_next < CW'(DEPTH);
    push_entry = '{pc: ImemAddr, inst: ImemData};
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (CLK),
    .rst       (Reset),
    .clear     (Redirect),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  // Request FSM; ImemReq and ImemAddr are registered alongside the state.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      ImemReq  <= 1'b0;
      ImemAddr <= align_word(RESET_PC);
      fetch_pc <= align_word(RESET_PC);
    end else begin
      case (state)
        IDLE: begin
          if (Redirect) begin
            fetch_pc <= target;
          end else if (credit) begin
            state    <= WAIT;
            ImemReq  <= 1'b1;
            ImemAddr <= fetch_pc;
            fetch_pc <= fetch_pc + 32'd4;
          end
        end
        WAIT: begin
          if (Redirect) begin
            fetch_pc <= target;
            if (ImemAck) begin
              state   <= IDLE;
              ImemReq <= 1'b0;
            end else begin
              state <= DROP;
            end
          end else if (ImemAck) begin
            if (credit) begin
              ImemAddr <= fetch_pc;
              fetch_pc <= fetch_pc + 32'd4;
            end else begin
              state   <= IDLE;
              ImemReq <= 1'b0;
            end
          end
        end
        DROP: begin
          if (Redirect) fetch_pc <= target;
          if (ImemAck) begin
            state   <= IDLE;
            ImemReq <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          ImemReq <= 1'b0;
        end
      endcase
    end
  end

  // Head presentation; an empty buffer shows PC 0 and a NOP.
  always_comb begin
    I_Valid = (count != '0);
    I_PC    = I_Valid ? head.pc : 32'h0000_0000;
    I_Inst  = I_Valid ? head.inst : NOP_INST;
    I_PC4   = I_PC + 32'd4;
  end

endmodule

// File: tb/tb_inst_fetch_buf.sv
// Directed bench for inst_fetch_buf: per-cycle vector table on a zero-wait
// memory, then hand sequences for slow memory, DROP and async reset.
module tb_inst_fetch_buf;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        Stall = 1'b0;
  logic        Redirect = 1'b0;
  logic [31:0] RedirTarg = 32'h0;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemAck = 1'b0;
  logic [31:0] ImemData = 32'h0;
  logic        I_Valid;
  logic [31:0] I_PC;
  logic [31:0] I_PC4;
  logic [31:0] I_Inst;

  int errors = 0;
  int checks = 0;

  int mem_lat = 0;
  int wait_cnt = 0;
  logic stray = 1'b1;

  inst_fetch_buf #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .Stall     (Stall),
    .Redirect  (Redirect),
    .RedirTarg (RedirTarg),
    .ImemReq   (ImemReq),
    .ImemAddr  (ImemAddr),
    .ImemAck   (ImemAck),
    .ImemData  (ImemData),
    .I_Valid   (I_Valid),
    .I_PC      (I_PC),
    .I_PC4     (I_PC4),
    .I_Inst    (I_Inst)
  );

  always #5 CLK = ~CLK;

  // Memory answers after mem_lat idle cycles; stray acks appear while idle.
  always @(negedge CLK) begin
    if (ImemReq) begin
      if (wait_cnt >= mem_lat) begin
        ImemAck  = 1'b1;
        ImemData = ImemAddr + 32'h0000_1000;
        wait_cnt = 0;
      end else begin
        ImemAck  = 1'b0;
        wait_cnt = wait_cnt + 1;
      end
    end else begin
      ImemAck  = stray;
      ImemData = 32'hDEAD_BEEF;
      wait_cnt = 0;
    end
  end

  typedef struct packed {
    logic        stall;
    logic        redir;
    logic [31:0] targ;
    logic        v;
    logic [31:0] pc;
    logic        req;
    logic [31:0] addr;
  } vec_t;

  vec_t vec [24];

  function automatic vec_t mk(input logic st, input logic rd, input logic [31:0] tg,
                              input logic v, input logic [31:0] pc,
                              input logic rq, input logic [31:0] ad);
    vec_t r;
    r.stall = st; r.redir = rd; r.targ = tg;
    r.v = v; r.pc = pc; r.req = rq; r.addr = ad;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic v, input logic [31:0] pc,
                            input logic rq, input logic [31:0] ad);
    logic [31:0] epc;
    epc = v ? pc : 32'h0;
    chk({tag, ".valid"}, {31'h0, I_Valid}, {31'h0, v});
    chk({tag, ".pc"}, I_PC, epc);
    chk({tag, ".pc4"}, I_PC4, epc + 32'd4);
    chk({tag, ".inst"}, I_Inst, v ? epc + 32'h0000_1000 : 32'h0);
    chk({tag, ".req"}, {31'h0, ImemReq}, {31'h0, rq});
    if (rq) chk({tag, ".addr"}, ImemAddr, ad);
    else    chk({tag, ".addr_hold"}, ImemAddr, ad);
  endtask

  task automatic cyc(input string tag, input logic v, input logic [31:0] pc,
                     input logic rq, input logic [31:0] ad);
    @(negedge CLK);
    check_outs(tag, v, pc, rq, ad);
  endtask

  initial begin
    //          stall redir targ           v  pc             req addr
    vec[0]  = mk(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0);
    vec[1]  = mk(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0);
    vec[2]  = mk(1'b0, 1'b0, 32'h0,        1'b1, 32'h0,        1'b1, 32'h4);
    vec[3]  = mk(1'b0, 1'b0, 32'h0,        1'b1, 32'h4,        1'b1, 32'h8);
    vec[4]  = mk(1'b0, 1'b0, 32'h0,        1'b1, 32'h8,        1'b1, 32'hC);
    vec[5]  = mk(1'b1, 1'b0, 32'h0,        1'b1, 32'hC,        1'b1, 32'h10);
    vec[6]  = mk(1'b1, 1'b0, 32'h0,        1'b1, 32'hC,        1'b1, 32'h14);
    vec[7]  = mk(1'b1, 1'b0, 32'h0,        1'b1, 32'hC,        1'b1, 32'h18);
    vec[8]  = mk(1'b1, 1'b0, 32'h0,        1'b1, 32'hC,        1'b0, 32'h18);
    vec[9]  = mk(1'b1, 1'b0, 32'h0,        1'b1, 32'hC,        1'b0, 32'h18);
    vec[10] = mk(1'b1, 1'b0, 32'h0,        1'b1, 32'hC,        1'b0, 32'h18);
    vec[11] = mk(1'b0, 1'b0, 32'h0,        1'b1, 32'hC,        1'b0, 32'h18);
    vec[12] = mk(1'b0, 1'b0, 32'h0,        1'b1, 32'h10,       1'b1, 32'h1C);
    vec[13] = mk(1'b0, 1'b0, 32'h0,        1'b1, 32'h14,       1'b1, 32'h20);
    vec[14] = mk(1'b0, 1'b0, 32'h0,        1'b1, 32'h18,       1'b1, 32'h24);
    vec[15] = mk(1'b0, 1'b0, 32'h0,        1'b1, 32'h1C,       1'b1, 32'h28);
    vec[16] = mk(1'b0, 1'b1, 32'h100,      1'b1, 32'h20,       1'b1, 32'h2C);
    vec[17] = mk(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h2C);
    vec[18] = mk(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h100);
    vec[19] = mk(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1, 32'h100,     1'b1, 32'h104);
    vec[20] = mk(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h104);
    vec[21] = mk(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'hFFFF_FFFC);
    vec[22] = mk(1'b0, 1'b0, 32'h0,        1'b1, 32'hFFFF_FFFC, 1'b1, 32'h0);
    vec[23] = mk(1'b0, 1'b0, 32'h0,        1'b1, 32'h0,        1'b1, 32'h4);

    repeat (2) @(negedge CLK);
    Reset = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (i > 0) @(negedge CLK);
      check_outs($sformatf("vec%0d", i), vec[i].v, vec[i].pc, vec[i].req, vec[i].addr);
      Stall     = vec[i].stall;
      Redirect  = vec[i].redir;
      RedirTarg = vec[i].targ;
    end

    // Reset while a request is outstanding must drop ImemReq before any edge.
    @(negedge CLK);
    Reset = 1'b1;
    #1;
    chk("async_rst.req", {31'h0, ImemReq}, 32'h0);
    chk("async_rst.valid", {31'h0, I_Valid}, 32'h0);
    mem_lat = 2;
    stray   = 1'b0;
    repeat (2) @(negedge CLK);
    Reset = 1'b0;
    check_outs("lat0", 1'b0, 32'h0, 1'b0, 32'h0);

    // Three-cycle memory: address stable for three cycles, one result per three.
    for (int n = 1; n <= 10; n++) begin
      cyc($sformatf("lat%0d", n), (n >= 4) && (n % 3 == 1), ((n - 4) / 3) * 4,
          1'b1, ((n - 1) / 3) * 4);
    end
    Redirect  = 1'b1;
    RedirTarg = 32'h0000_0040;

    // Redirect two cycles before the ack: old address held, response squashed.
    cyc("drop11", 1'b0, 32'h0, 1'b1, 32'hC);
    Redirect = 1'b0;
    cyc("drop12", 1'b0, 32'h0, 1'b1, 32'hC);
    cyc("drop13", 1'b0, 32'h0, 1'b0, 32'hC);
    cyc("drop14", 1'b0, 32'h0, 1'b1, 32'h40);
    cyc("drop15", 1'b0, 32'h0, 1'b1, 32'h40);
    cyc("drop16", 1'b0, 32'h0, 1'b1, 32'h40);
    cyc("drop17", 1'b1, 32'h40, 1'b1, 32'h44);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
